sync_fifo_flags: RTL and testbench
==================================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 The module SHALL have parameter BITS, default 8, giving the data width in bits.
REQ-002 The module SHALL have parameter WORDS, default 4, giving log2 of depth; DEPTH = 2**WORDS entries.
REQ-003 The module SHALL have parameter AF_LEVEL, default DEPTH-2, the almost-full threshold in entries.
REQ-004 The module SHALL have parameter AE_LEVEL, default 2, the almost-empty threshold in entries.
REQ-005 The module SHALL have parameter FWFT, default 0, where 0 selects registered-read mode and 1 selects first-word-fall-through mode.
REQ-006 CLK  input  1  the single clock; all state changes on the rising edge.
REQ-007 RESET  input  1  asynchronous, active-high reset.
REQ-008 WE  input  1  write request.
REQ-009 RE  input  1  read request.
REQ-010 DATAIN  input  BITS  write data.
REQ-011 Q  output  BITS  read data.
REQ-012 FULL  output  1  COUNT == DEPTH.
REQ-013 EMPTY  output  1  COUNT == 0.
REQ-014 ALMOST_FULL  output  1  COUNT >= AF_LEVEL.
REQ-015 ALMOST_EMPTY  output  1  COUNT <= AE_LEVEL.
REQ-016 COUNT  output  WORDS+1  current occupancy, 0..DEPTH.
REQ-017 OVERFLOW  output  1  one-cycle pulse flagging a rejected write.
REQ-018 UNDERFLOW  output  1  one-cycle pulse flagging a rejected read.

Function
REQ-019 A write SHALL be accepted when WE=1 and FULL=0: DATAIN is stored at the write pointer, which then increments modulo DEPTH.
REQ-020 A read SHALL be accepted when RE=1 and EMPTY=0: the read pointer increments modulo DEPTH.
REQ-021 WE=1 while FULL=1 SHALL be rejected, even when RE=1 in the same cycle; no storage or pointer change occurs.
REQ-022 RE=1 while EMPTY=1 SHALL be rejected, even when WE=1 in the same cycle; no pointer change occurs and Q is unchanged.
REQ-023 COUNT SHALL be a register: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither are accepted.
REQ-024 FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY SHALL be decoded from the registered COUNT, so each reflects an accepted operation one cycle after its edge.
REQ-025 OVERFLOW and UNDERFLOW SHALL be registered, asserting for exactly the one cycle after the rejected request's edge.
REQ-026 FWFT=0: Q SHALL load the entry at the read pointer on the edge that accepts a read (one-cycle latency) and SHALL hold otherwise.
REQ-027 FWFT=1: Q SHALL present the entry at the read pointer whenever EMPTY=0, so the first written word is visible the cycle EMPTY falls; RE acknowledges that word and advances to the next.
REQ-028 FWFT=1 with EMPTY=1: Q SHALL hold its last value.
REQ-029 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication of data; ordering SHALL be strictly first-in first-out.
REQ-030 Elaboration SHALL fail when AF_LEVEL > DEPTH or AE_LEVEL >= DEPTH.

Reset
REQ-031 RESET=1 SHALL asynchronously clear both pointers, COUNT, Q, OVERFLOW and UNDERFLOW to 0, giving EMPTY=1, ALMOST_EMPTY=1, FULL=0 and ALMOST_FULL=0.
REQ-032 Storage contents SHALL NOT be reset; a reset mid-operation discards all queued data.
REQ-033 While RESET=1, WE and RE SHALL be ignored.

Structure
REQ-034 Package fifo_pkg SHALL hold the clog2 helper function, the FWFT mode constants and the default thresholds, shared with ASYNCFIFO.
REQ-035 Storage SHALL be a sub-module fifo_ram: simple dual-port, synchronous write, with the read port style selected by FWFT; all control logic lives in sync_fifo_flags.

Verification
REQ-036 Reset, then 16 writes of 0x00..0x0F with default parameters -> FULL=1, COUNT=16, ALMOST_FULL first seen after the 14th write.
REQ-037 17th write of 0xAA while FULL -> OVERFLOW pulses high for one cycle; draining 16 reads returns 0x00..0x0F in order, 0xAA is never seen.
REQ-038 RE while EMPTY, with WE=1 in the same cycle -> UNDERFLOW pulses, COUNT=1 next cycle, Q unchanged.
REQ-039 At COUNT=8, simultaneous WE and RE for 40 cycles with incrementing data -> COUNT remains 8, output sequence matches input, pointers wrap twice.
REQ-040 FWFT=1, single write of 0x5C -> next cycle EMPTY=0 and Q=0x5C before any RE; RE then gives EMPTY=1.
REQ-041 Assert RESET asynchronously mid-cycle at COUNT=5 -> all outputs reach their reset values immediately; a following write/read returns the new data only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: width helper, read-mode constants and default flag
// thresholds, common to the synchronous and asynchronous FIFO families.
package fifo_pkg;

    // Read-port modes: registered read, or first-word-fall-through
    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    // Default geometry and flag thresholds
    localparam int unsigned DEFAULT_BITS      = 8;
    localparam int unsigned DEFAULT_WORDS     = 4;
    localparam int unsigned DEFAULT_AE_LEVEL  = 2;
    localparam int unsigned DEFAULT_AF_MARGIN = 2;

    // Ceiling log2, usable in constant expressions
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                result = result + 1;
                v      = v >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port FIFO storage: synchronous write; the read port is either
// combinational (fall-through mode) or a registered read with enable.
// Ports:
//   clk      - clock
//   wr_en    - write strobe, wr_addr / wr_data give location and value
//   rd_en    - read strobe (registered mode only), rd_addr gives location
//   rd_data  - read data
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned BITS   = DEFAULT_BITS,
    parameter int unsigned DEPTH  = 2 ** DEFAULT_WORDS,
    parameter int unsigned FWFT   = FWFT_OFF,
    localparam int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BITS-1:0]   wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BITS-1:0]   rd_data
);

    // Storage array; intentionally never reset
    logic [BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_async_rd
            // Head entry is always visible; the controller owns the hold register
            logic unused_rd_en;
            assign unused_rd_en = rd_en;
            assign rd_data      = mem[rd_addr];
        end else begin : g_reg_rd
            // Output register loads only on an accepted read and holds otherwise
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    rd_data <= mem[rd_addr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, full/empty/almost flags and
// registered overflow/underflow pulses. Read port is registered (FWFT=0)
// or first-word-fall-through (FWFT=1).
// Ports:
//   CLK, RESET        - clock, asynchronous active-high reset
//   WE, DATAIN        - write request and data
//   RE                - read request (acknowledge of the head word in FWFT mode)
//   Q                 - read data
//   FULL, EMPTY       - COUNT == DEPTH, COUNT == 0
//   ALMOST_FULL/EMPTY - COUNT >= AF_LEVEL, COUNT <= AE_LEVEL
//   COUNT             - occupancy 0..DEPTH
//   OVERFLOW          - one-cycle pulse after a rejected write
//   UNDERFLOW         - one-cycle pulse after a rejected read
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned BITS     = DEFAULT_BITS,
    parameter int unsigned WORDS    = DEFAULT_WORDS,
    parameter int unsigned AF_LEVEL = (2 ** WORDS) - DEFAULT_AF_MARGIN,
    parameter int unsigned AE_LEVEL = DEFAULT_AE_LEVEL,
    parameter int unsigned FWFT     = FWFT_OFF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WE,
    input  logic             RE,
    input  logic [BITS-1:0]  DATAIN,
    output logic [BITS-1:0]  Q,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output logic [WORDS:0]   COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam int unsigned DEPTH   = 2 ** WORDS;
    localparam int unsigned COUNT_W = WORDS + 1;

    // Threshold sanity: almost-full must be reachable, almost-empty must be below full
    generate
        if (AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_levels
            $error("sync_fifo_flags: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");
        end
    endgenerate

    logic [WORDS-1:0]   wr_ptr;
    logic [WORDS-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count_q;
    logic               overflow_q;
    logic               underflow_q;
    logic               wr_accept;
    logic               rd_accept;
    logic [BITS-1:0]    ram_rd_data;

    // Flags decode from the registered count
    assign COUNT        = count_q;
    assign FULL         = (count_q == COUNT_W'(DEPTH));
    assign EMPTY        = (count_q == '0);
    assign ALMOST_FULL  = (count_q >= COUNT_W'(AF_LEVEL));
    assign ALMOST_EMPTY = (count_q <= COUNT_W'(AE_LEVEL));
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

    // Requests are gated by the pre-edge flags, so a full FIFO rejects a write
    // even if a read frees a slot on the same edge (and likewise for empty).
    assign wr_accept = WE && !FULL;
    assign rd_accept = RE && !EMPTY;

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy count: simultaneous accepted write and read cancel out
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Rejected-request pulses, high for the single cycle after the edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= WE && FULL;
            underflow_q <= RE && EMPTY;
        end
    end

    fifo_ram #(
        .BITS  (BITS),
        .DEPTH (DEPTH),
        .FWFT  (FWFT)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (DATAIN),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft_q
            // Remember the last word acknowledged so Q holds while empty
            logic [BITS-1:0] q_hold;
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    q_hold <= '0;
                end else if (rd_accept) begin
                    q_hold <= ram_rd_data;
                end
            end
            assign Q = EMPTY ? q_hold : ram_rd_data;
        end else begin : g_reg_q
            // The RAM output register is not reset; mask it until the first
            // read after reset so Q reads zero out of reset.
            logic q_loaded;
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    q_loaded <= 1'b0;
                end else if (rd_accept) begin
                    q_loaded <= 1'b1;
                end
            end
            assign Q = q_loaded ? ram_rd_data : '0;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: registered-read instance driven
// through a data scoreboard, plus a fall-through instance.
module tb_sync_fifo_flags;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;

    logic       we  = 1'b0;
    logic       re  = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] q;
    logic       full, empty, af, ae, ovf, unf;
    logic [4:0] count;

    logic       f_we  = 1'b0;
    logic       f_re  = 1'b0;
    logic [7:0] f_din = 8'h00;
    logic [7:0] f_q;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] f_count;

    int         passed = 0;
    int         total  = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_q = 8'h00;

    always #5 CLK = ~CLK;

    sync_fifo_flags #(.BITS(8), .WORDS(4), .FWFT(0)) u_dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .WE           (we),
        .RE           (re),
        .DATAIN       (din),
        .Q            (q),
        .FULL         (full),
        .EMPTY        (empty),
        .ALMOST_FULL  (af),
        .ALMOST_EMPTY (ae),
        .COUNT        (count),
        .OVERFLOW     (ovf),
        .UNDERFLOW    (unf)
    );

    sync_fifo_flags #(.BITS(8), .WORDS(4), .FWFT(1)) u_fwft (
        .CLK          (CLK),
        .RESET        (RESET),
        .WE           (f_we),
        .RE           (f_re),
        .DATAIN       (f_din),
        .Q            (f_q),
        .FULL         (f_full),
        .EMPTY        (f_empty),
        .ALMOST_FULL  (f_af),
        .ALMOST_EMPTY (f_ae),
        .COUNT        (f_count),
        .OVERFLOW     (f_ovf),
        .UNDERFLOW    (f_unf)
    );

    // Drive one clock of requests on the registered-read instance and update
    // the scoreboard from the occupancy seen before the edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        int n;
        n   = sb.size();
        we  = w;
        re  = r;
        din = d;
        if (r && n > 0) exp_q = sb.pop_front();
        if (w && n < 16) sb.push_back(d);
        @(posedge CLK);
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic fcycle(input logic w, input logic r, input logic [7:0] d);
        f_we  = w;
        f_re  = r;
        f_din = d;
        @(posedge CLK);
        #1;
        f_we = 1'b0;
        f_re = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passed++;
        total++; if (ae !== 1'b1) $display("FAIL reset_almost_empty got %b exp 1", ae); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passed++;
        total++; if (af !== 1'b0) $display("FAIL reset_almost_full got %b exp 0", af); else passed++;
        total++; if (q !== 8'h00) $display("FAIL reset_q got %h exp 00", q); else passed++;
        total++; if (ovf !== 1'b0 || unf !== 1'b0) $display("FAIL reset_pulses got %b%b exp 00", ovf, unf); else passed++;
        @(negedge CLK);
        RESET = 1'b0;
        sb.delete();
        exp_q = 8'h00;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_fill();
        logic exp_b;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            total++; if (count !== 5'(i + 1)) $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); else passed++;
            exp_b = (i + 1 >= 14);
            total++; if (af !== exp_b) $display("FAIL fill_almost_full[%0d] got %b exp %b", i, af, exp_b); else passed++;
            exp_b = (i + 1 <= 2);
            total++; if (ae !== exp_b) $display("FAIL fill_almost_empty[%0d] got %b exp %b", i, ae, exp_b); else passed++;
        end
        total++; if (full !== 1'b1) $display("FAIL fill_full got %b exp 1", full); else passed++;
        total++; if (empty !== 1'b0) $display("FAIL fill_empty got %b exp 0", empty); else passed++;
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, 8'hAA);
        total++; if (ovf !== 1'b1) $display("FAIL ovf_pulse got %b exp 1", ovf); else passed++;
        total++; if (count !== 5'd16) $display("FAIL ovf_count got %0d exp 16", count); else passed++;
        cycle(1'b0, 1'b0, 8'h00);
        total++; if (ovf !== 1'b0) $display("FAIL ovf_one_cycle got %b exp 0", ovf); else passed++;
        // Write while full is rejected even with a same-cycle read
        cycle(1'b1, 1'b1, 8'hBB);
        total++; if (ovf !== 1'b1) $display("FAIL ovf_with_read got %b exp 1", ovf); else passed++;
        total++; if (count !== 5'(sb.size())) $display("FAIL ovf_rw_count got %0d exp %0d", count, sb.size()); else passed++;
        total++; if (q !== exp_q) $display("FAIL ovf_rw_q got %h exp %h", q, exp_q); else passed++;
        while (sb.size() > 0) begin
            cycle(1'b0, 1'b1, 8'h00);
            total++; if (q !== exp_q) $display("FAIL drain_q got %h exp %h", q, exp_q); else passed++;
        end
        total++; if (empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", empty); else passed++;
        total++; if (count !== 5'd0) $display("FAIL drain_count got %0d exp 0", count); else passed++;
    endtask

    task automatic test_underflow();
        logic [7:0] q_before;
        q_before = exp_q;
        cycle(1'b1, 1'b1, 8'h33);
        total++; if (unf !== 1'b1) $display("FAIL unf_pulse got %b exp 1", unf); else passed++;
        total++; if (count !== 5'd1) $display("FAIL unf_count got %0d exp 1", count); else passed++;
        total++; if (q !== q_before) $display("FAIL unf_q_hold got %h exp %h", q, q_before); else passed++;
        cycle(1'b0, 1'b0, 8'h00);
        total++; if (unf !== 1'b0) $display("FAIL unf_one_cycle got %b exp 0", unf); else passed++;
        cycle(1'b0, 1'b1, 8'h00);
        total++; if (q !== exp_q) $display("FAIL unf_next_read got %h exp %h", q, exp_q); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL unf_empty got %b exp 1", empty); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
        total++; if (count !== 5'd8) $display("FAIL b2b_prefill got %0d exp 8", count); else passed++;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h48 + i));
            total++; if (count !== 5'd8) $display("FAIL b2b_count[%0d] got %0d exp 8", i, count); else passed++;
            total++; if (q !== exp_q) $display("FAIL b2b_q[%0d] got %h exp %h", i, q, exp_q); else passed++;
        end
        while (sb.size() > 0) begin
            cycle(1'b0, 1'b1, 8'h00);
            total++; if (q !== exp_q) $display("FAIL b2b_drain_q got %h exp %h", q, exp_q); else passed++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        cycle(1'b0, 1'b1, 8'h00);
        total++; if (count !== 5'd5) $display("FAIL ares_pre_count got %0d exp 5", count); else passed++;
        total++; if (q !== 8'h60) $display("FAIL ares_pre_q got %h exp 60", q); else passed++;
        #3;
        RESET = 1'b1;
        #1;
        total++; if (count !== 5'd0) $display("FAIL ares_count got %0d exp 0", count); else passed++;
        total++; if (empty !== 1'b1 || ae !== 1'b1) $display("FAIL ares_empty_flags got %b%b exp 11", empty, ae); else passed++;
        total++; if (full !== 1'b0 || af !== 1'b0) $display("FAIL ares_full_flags got %b%b exp 00", full, af); else passed++;
        total++; if (q !== 8'h00) $display("FAIL ares_q got %h exp 00", q); else passed++;
        sb.delete();
        exp_q = 8'h00;
        @(negedge CLK);
        RESET = 1'b0;
        cycle(1'b1, 1'b0, 8'h77);
        cycle(1'b0, 1'b1, 8'h00);
        total++; if (q !== exp_q) $display("FAIL ares_new_data got %h exp %h", q, exp_q); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL ares_drained got %b exp 1", empty); else passed++;
    endtask

    task automatic test_fwft();
        total++; if (f_empty !== 1'b1 || f_q !== 8'h00) $display("FAIL fwft_idle got empty=%b q=%h exp 1/00", f_empty, f_q); else passed++;
        total++; if ({f_full, f_af, f_ae, f_ovf, f_unf} !== 5'b00100)
            $display("FAIL fwft_idle_flags got %b exp 00100", {f_full, f_af, f_ae, f_ovf, f_unf}); else passed++;
        fcycle(1'b1, 1'b0, 8'h5C);
        total++; if (f_empty !== 1'b0) $display("FAIL fwft_not_empty got %b exp 0", f_empty); else passed++;
        total++; if (f_q !== 8'h5C) $display("FAIL fwft_fall_through got %h exp 5c", f_q); else passed++;
        total++; if (f_count !== 5'd1) $display("FAIL fwft_count got %0d exp 1", f_count); else passed++;
        fcycle(1'b0, 1'b1, 8'h00);
        total++; if (f_empty !== 1'b1) $display("FAIL fwft_ack_empty got %b exp 1", f_empty); else passed++;
        total++; if (f_q !== 8'h5C) $display("FAIL fwft_hold got %h exp 5c", f_q); else passed++;
        fcycle(1'b1, 1'b0, 8'h11);
        total++; if (f_q !== 8'h11) $display("FAIL fwft_head got %h exp 11", f_q); else passed++;
        fcycle(1'b1, 1'b0, 8'h22);
        fcycle(1'b0, 1'b1, 8'h00);
        total++; if (f_q !== 8'h22) $display("FAIL fwft_advance got %h exp 22", f_q); else passed++;
        fcycle(1'b0, 1'b1, 8'h00);
        total++; if (f_empty !== 1'b1 || f_q !== 8'h22) $display("FAIL fwft_last_hold got empty=%b q=%h exp 1/22", f_empty, f_q); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_async_reset();
        test_fwft();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
